// File: rtl/ex_operand_stage.sv
// Execute-stage pipeline register and operand bypass network.
// Holds one decoded instruction and drives the ALU with forwarded operands.
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ds_valid,
    output logic          es_allowin,
    input  logic [2:0]    ds_aluop,
    input  logic [RW-1:0] ds_rs1,
    input  logic [RW-1:0] ds_rs2,
    input  logic [DW-1:0] ds_rs1_data,
    input  logic [DW-1:0] ds_rs2_data,
    input  logic [DW-1:0] ds_imm,
    input  logic          ds_use_imm,
    input  logic [RW-1:0] ds_rd,
    input  logic          ds_reg_we,
    input  logic          flush,
    input  logic          ms_allowin,
    input  logic          ms_fwd_we,
    input  logic [RW-1:0] ms_fwd_rd,
    input  logic [DW-1:0] ms_fwd_data,
    input  logic          ws_fwd_we,
    input  logic [RW-1:0] ws_fwd_rd,
    input  logic [DW-1:0] ws_fwd_data,
    output logic          es_valid,
    output logic [2:0]    es_aluop,
    output logic [DW-1:0] es_vsrc1,
    output logic [DW-1:0] es_vsrc2,
    output logic [RW-1:0] es_rd,
    output logic          es_reg_we
);

    logic [2:0]    aluop_q;
    logic [RW-1:0] rs1_q, rs2_q, rd_q;
    logic [DW-1:0] op1_q, op2_q, imm_q;
    logic          use_imm_q, reg_we_q;

    logic          capture, holding;
    logic          ws_hit_ds1, ws_hit_ds2, ws_hit_q1, ws_hit_q2;
    logic [DW-1:0] fwd1, fwd2;

    assign es_allowin = !es_valid || ms_allowin;
    assign capture    = ds_valid && es_allowin;
    assign holding    = es_valid && !es_allowin;

    // A WB write landing in the same cycle as a register-file read or a stall
    // must be folded into the stored operand, or it is lost once WB retires.
    assign ws_hit_ds1 = ws_fwd_we && (ds_rs1 != '0) && (ws_fwd_rd == ds_rs1);
    assign ws_hit_ds2 = ws_fwd_we && (ds_rs2 != '0) && (ws_fwd_rd == ds_rs2);
    assign ws_hit_q1  = ws_fwd_we && (rs1_q  != '0) && (ws_fwd_rd == rs1_q);
    assign ws_hit_q2  = ws_fwd_we && (rs2_q  != '0) && (ws_fwd_rd == rs2_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (flush) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aluop_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
            reg_we_q  <= 1'b0;
        end else if (capture) begin
            aluop_q   <= ds_aluop;
            rs1_q     <= ds_rs1;
            rs2_q     <= ds_rs2;
            op1_q     <= ws_hit_ds1 ? ws_fwd_data : ds_rs1_data;
            op2_q     <= ws_hit_ds2 ? ws_fwd_data : ds_rs2_data;
            imm_q     <= ds_imm;
            use_imm_q <= ds_use_imm;
            rd_q      <= ds_rd;
            reg_we_q  <= ds_reg_we;
        end else if (holding) begin
            if (ws_hit_q1) op1_q <= ws_fwd_data;
            if (ws_hit_q2) op2_q <= ws_fwd_data;
        end
    end

    // MEM is younger than WB, so its result wins when both target the same register.
    always_comb begin
        fwd1 = op1_q;
        if (rs1_q == '0)
            fwd1 = '0;
        else if (ms_fwd_we && (ms_fwd_rd == rs1_q))
            fwd1 = ms_fwd_data;
        else if (ws_fwd_we && (ws_fwd_rd == rs1_q))
            fwd1 = ws_fwd_data;

        fwd2 = op2_q;
        if (rs2_q == '0)
            fwd2 = '0;
        else if (ms_fwd_we && (ms_fwd_rd == rs2_q))
            fwd2 = ms_fwd_data;
        else if (ws_fwd_we && (ws_fwd_rd == rs2_q))
            fwd2 = ws_fwd_data;
    end

    assign es_vsrc1  = fwd1;
    assign es_vsrc2  = use_imm_q ? imm_q : fwd2;
    assign es_aluop  = aluop_q;
    assign es_rd     = rd_q;
    assign es_reg_we = reg_we_q && es_valid;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Pipeline register and operand-bypass stage directly upstream of the ALU.
- Accepts decoded instructions from decode and holds them with a valid/allowin handshake.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU's aluop, vsrc1 and vsrc2 inputs, and supports stall back-pressure and flush.

Parameters:
- DW, 32, datapath width; must match the ALU operand width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- ds_valid  in  1  decode stage offers an instruction.
- es_allowin  out  1  this stage can accept this cycle.
- ds_aluop  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 slt, 101 branch-compare).
- ds_rs1, ds_rs2  in  RW  source register indices.
- ds_rs1_data, ds_rs2_data  in  DW  register-file read data.
- ds_imm  in  DW  sign-extended immediate.
- ds_use_imm  in  1  vsrc2 takes the immediate instead of rs2.
- ds_rd  in  RW  destination index.
- ds_reg_we  in  1  instruction writes rd.
- flush  in  1  kill the held instruction (branch taken / exception).
- ms_allowin  in  1  downstream can accept.
- ms_fwd_we  in  1  MEM-stage result valid for forwarding.
- ms_fwd_rd  in  RW  MEM-stage destination.
- ms_fwd_data  in  DW  MEM-stage result.
- ws_fwd_we  in  1  WB-stage write enable.
- ws_fwd_rd  in  RW  WB-stage destination.
- ws_fwd_data  in  DW  WB-stage write data.
- es_valid  out  1  stage holds a live instruction.
- es_aluop  out  3  to ALU aluop.
- es_vsrc1  out  DW  to ALU vsrc1.
- es_vsrc2  out  DW  to ALU vsrc2.
- es_rd  out  RW  held destination.
- es_reg_we  out  1  held write enable, gated by es_valid.

Behaviour:
- Reset (resetn=0, asynchronous): es_valid=0. All held fields (aluop, rs1, rs2, op1, op2, imm, use_imm, rd, reg_we) are 0. Therefore es_aluop=0, es_vsrc1=0, es_vsrc2=0, es_rd=0, es_reg_we=0. Reset takes effect immediately, mid-transaction included; no partial state survives.
- Handshake:
  - es_allowin = !es_valid | ms_allowin.
  - Handoff to MEM occurs when es_valid & ms_allowin.
  - Capture when ds_valid & es_allowin: all ds_* fields are latched at the rising edge.
- es_valid next-state:
  - flush → 0.
  - else es_allowin → ds_valid.
  - else hold.
  - flush has priority over a simultaneous capture; the incoming instruction is discarded and es_allowin does not depend on flush.
- Latency: one cycle decode→ALU inputs; zero added cycles on forwarding.
- Operand resolution, per source s in {1,2}, combinational on the held fields:
  - rs_s==0 → 0.
  - else ms_fwd_we & ms_fwd_rd==rs_s → ms_fwd_data.
  - else ws_fwd_we & ws_fwd_rd==rs_s → ws_fwd_data.
  - else held op_s.
  - MEM has priority over WB when both match.
- Writeback snoop while holding: each cycle that es_valid & !es_allowin holds, if ws_fwd_we & ws_fwd_rd!=0 & ws_fwd_rd==rs_s, then op_s ← ws_fwd_data. This keeps stalled operands correct after the producer retires.
- Capture-cycle write: on a capture edge, if ws_fwd_we with ws_fwd_rd matching ds_rs_s (≠0), latch ws_fwd_data instead of ds_rs_s_data. This covers register-file write/read in the same cycle.
- es_vsrc2: use_imm → held imm, bypassing all forwarding; else resolved operand 2. es_vsrc1 is always resolved operand 1.
- es_aluop and es_rd are driven from held fields regardless of es_valid. es_reg_we = held reg_we & es_valid.
- Forwarding inputs are ignored for the resolved value only when index 0 is involved; rd=0 never forwards.

Test Plan:
- Reset: assert resetn=0 mid-capture with ds_valid=1 → es_valid=0, es_vsrc1=0, es_vsrc2=0, es_reg_we=0 immediately; capture resumes on the first edge after release.
- Basic capture: ds_valid=1, aluop=000, rs1_data=5, rs2_data=7, ms_allowin=1 → next cycle es_valid=1, es_vsrc1=5, es_vsrc2=7, es_aluop=000.
- Forward priority: held rs1=3 with op1=1, ms_fwd_we=1 ms_fwd_rd=3 ms_fwd_data=0xAA, ws_fwd_we=1 ws_fwd_rd=3 ws_fwd_data=0xBB → es_vsrc1=0xAA; drop ms_fwd_we → 0xBB; rs1=0 with both matching rd=0 → 0.
- Stall with snoop: es_valid=1, ms_allowin=0, rs2=4; ws writes r4=0x1234 → es_allowin=0, op held, es_vsrc2 stays 0x1234 after ws_fwd_we drops; ds_valid is not accepted while stalled.
- Immediate: use_imm=1, imm=0xFFFFFFF0, ms forwarding on rs2 → es_vsrc2=0xFFFFFFF0.
- Flush: flush=1 with ds_valid=1, es_allowin=1 → next cycle es_valid=0, es_reg_we=0; next ds_valid captures normally.
